// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the two-way stream demultiplexer
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/lane_reg.sv
// rtl/lane_reg.sv - one-entry output lane register with EMPTY/FULL control and delivery counter
module lane_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             free,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    lane_state_t state_q;
    lane_state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load wins over a drain, so a word can pass through a full lane without a bubble.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (state_q == FULL && ready) begin
            state_d = EMPTY;
        end
    end

    assign valid = (state_q == FULL);
    assign free  = (state_q == EMPTY) || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (valid && ready) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/stream_demux2.sv
// rtl/stream_demux2.sv - two-way valid/ready stream demultiplexer, steer or alternate mode
module stream_demux2
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic             next_lane
);

    logic tgt;
    logic free0;
    logic free1;
    logic hs;
    logic load0;
    logic load1;

    assign tgt      = in_mode ? next_lane : in_sel;
    assign in_ready = (tgt == LANE1) ? free1 : free0;
    assign hs       = in_valid && in_ready;
    assign load0    = hs && (tgt == LANE0);
    assign load1    = hs && (tgt == LANE1);

    // next_lane survives mode switches; only alternate-mode accepts advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_lane <= LANE0;
        end else if (hs && in_mode) begin
            next_lane <= ~next_lane;
        end
    end

    lane_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lane0 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load0),
        .d     (in_data),
        .valid (out0_valid),
        .ready (out0_ready),
        .q     (out0_data),
        .free  (free0),
        .count (count0)
    );

    lane_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lane1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load1),
        .d     (in_data),
        .valid (out1_valid),
        .ready (out1_ready),
        .q     (out1_data),
        .free  (free1),
        .count (count1)
    );

endmodule

// File: tb/tb_stream_demux2.sv
// tb/tb_stream_demux2.sv - scoreboard bench for stream_demux2
module tb_stream_demux2;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] count0;
    logic [7:0] count1;
    logic       next_lane;

    int n_check;
    int n_pass;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] m_cnt0;
    logic [7:0] m_cnt1;
    logic       m_nl;

    stream_demux2 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_mode    (in_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count0     (count0),
        .count1     (count1),
        .next_lane  (next_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare against the model state, then apply this cycle's handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            logic lane;
            logic exp_rdy;
            lane    = in_mode ? m_nl : in_sel;
            exp_rdy = lane ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
            n_check++;
            if (in_ready !== exp_rdy) $display("FAIL sb_in_ready got=%b exp=%b t=%0t", in_ready, exp_rdy, $time);
            else n_pass++;
            n_check++;
            if (out0_valid !== (q0.size() != 0)) $display("FAIL sb_out0_valid got=%b exp=%b t=%0t", out0_valid, q0.size() != 0, $time);
            else n_pass++;
            n_check++;
            if (out1_valid !== (q1.size() != 0)) $display("FAIL sb_out1_valid got=%b exp=%b t=%0t", out1_valid, q1.size() != 0, $time);
            else n_pass++;
            if (q0.size() != 0) begin
                n_check++;
                if (out0_data !== q0[0]) $display("FAIL sb_out0_data got=%h exp=%h t=%0t", out0_data, q0[0], $time);
                else n_pass++;
            end
            if (q1.size() != 0) begin
                n_check++;
                if (out1_data !== q1[0]) $display("FAIL sb_out1_data got=%h exp=%h t=%0t", out1_data, q1[0], $time);
                else n_pass++;
            end
            n_check++;
            if (count0 !== m_cnt0) $display("FAIL sb_count0 got=%0d exp=%0d t=%0t", count0, m_cnt0, $time);
            else n_pass++;
            n_check++;
            if (count1 !== m_cnt1) $display("FAIL sb_count1 got=%0d exp=%0d t=%0t", count1, m_cnt1, $time);
            else n_pass++;
            n_check++;
            if (next_lane !== m_nl) $display("FAIL sb_next_lane got=%b exp=%b t=%0t", next_lane, m_nl, $time);
            else n_pass++;

            if (q0.size() != 0 && out0_ready) begin
                void'(q0.pop_front());
                m_cnt0 = m_cnt0 + 8'd1;
            end
            if (q1.size() != 0 && out1_ready) begin
                void'(q1.pop_front());
                m_cnt1 = m_cnt1 + 8'd1;
            end
            if (in_valid && exp_rdy) begin
                if (lane) q1.push_back(in_data);
                else q0.push_back(in_data);
                if (in_mode) m_nl = ~m_nl;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        m_nl   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        int n;
        n        = 0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            cyc();
            n++;
        end
        if (!in_ready) begin
            n_check++;
            $display("FAIL send_timeout data=%h got_ready=%b exp_ready=1", d, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_sel     = 1'b0;
        in_mode    = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        clear_model();
        #3;
        n_check++;
        if ({out0_valid, out1_valid} !== 2'b00) $display("FAIL reset_valid got=%b exp=00", {out0_valid, out1_valid});
        else n_pass++;
        n_check++;
        if ({out0_data, out1_data} !== 16'h0000) $display("FAIL reset_data got=%h exp=0000", {out0_data, out1_data});
        else n_pass++;
        n_check++;
        if ({count0, count1, next_lane} !== 17'd0) $display("FAIL reset_counts got=%h exp=0", {count0, count1, next_lane});
        else n_pass++;
        n_check++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else n_pass++;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_steer();
        in_mode = 1'b0;
        send(8'h11, 1'b0);
        n_check++;
        if (!(out0_valid === 1'b1 && out0_data === 8'h11)) $display("FAIL steer_w0 got=%b/%h exp=1/11", out0_valid, out0_data);
        else n_pass++;
        send(8'h22, 1'b1);
        n_check++;
        if (!(out1_valid === 1'b1 && out1_data === 8'h22)) $display("FAIL steer_w1 got=%b/%h exp=1/22", out1_valid, out1_data);
        else n_pass++;
        send(8'h33, 1'b0);
        in_valid = 1'b0;
        n_check++;
        if (!(out0_valid === 1'b1 && out0_data === 8'h33)) $display("FAIL steer_w2 got=%b/%h exp=1/33", out0_valid, out0_data);
        else n_pass++;
        cyc();
        cyc();
        n_check++;
        if ({count0, count1} !== {8'd2, 8'd1}) $display("FAIL steer_counts got=%0d/%0d exp=2/1", count0, count1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        in_mode    = 1'b0;
        out0_ready = 1'b0;
        send(8'hA5, 1'b0);
        in_data = 8'h5A;
        in_sel  = 1'b0;
        #1;
        n_check++;
        if (in_ready !== 1'b0) $display("FAIL bp_blocked got=%b exp=0", in_ready);
        else n_pass++;
        cyc();
        cyc();
        n_check++;
        if (!(out0_valid === 1'b1 && out0_data === 8'hA5)) $display("FAIL bp_hold got=%b/%h exp=1/a5", out0_valid, out0_data);
        else n_pass++;
        out0_ready = 1'b1;
        #1;
        n_check++;
        if (in_ready !== 1'b1) $display("FAIL bp_release got=%b exp=1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        n_check++;
        if (!(out0_valid === 1'b1 && out0_data === 8'h5A)) $display("FAIL bp_passthru got=%b/%h exp=1/5a", out0_valid, out0_data);
        else n_pass++;
    endtask

    task automatic test_independent();
        out1_ready = 1'b0;
        in_data    = 8'h77;
        in_sel     = 1'b1;
        in_valid   = 1'b1;
        #1;
        n_check++;
        if (in_ready !== 1'b1) $display("FAIL indep_ready got=%b exp=1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_check++;
        if (!(out1_valid === 1'b1 && out1_data === 8'h77)) $display("FAIL indep_lane1 got=%b/%h exp=1/77", out1_valid, out1_data);
        else n_pass++;
        n_check++;
        if (!(out0_valid === 1'b1 && out0_data === 8'h5A)) $display("FAIL indep_lane0 got=%b/%h exp=1/5a", out0_valid, out0_data);
        else n_pass++;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_alternate();
        in_mode = 1'b1;
        n_check++;
        if (next_lane !== 1'b0) $display("FAIL alt_start got=%b exp=0", next_lane);
        else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            logic [7:0] w;
            w        = 8'(i);
            in_data  = w;
            in_sel   = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_check++;
            if (next_lane !== w[0]) $display("FAIL alt_next_lane word=%0d got=%b exp=%b", i, next_lane, w[0]);
            else n_pass++;
            n_check++;
            if (w[0] && out0_data !== w) $display("FAIL alt_lane0 got=%h exp=%h", out0_data, w);
            else if (!w[0] && out1_data !== w) $display("FAIL alt_lane1 got=%h exp=%h", out1_data, w);
            else n_pass++;
        end
        in_valid = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        clear_model();
        cyc();
        rst_n      = 1'b1;
        in_mode    = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        cyc();
        for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
        in_valid = 1'b0;
        cyc();
        cyc();
        n_check++;
        if ({count0, count1} !== 16'h0000) $display("FAIL wrap_counts got=%0d/%0d exp=0/0", count0, count1);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        in_mode = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 1'b1);
        in_valid = 1'b0;
        cyc();
        cyc();
        out1_ready = 1'b0;
        in_mode    = 1'b1;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        #1;
        n_check++;
        if ({count0, count1, next_lane} !== {8'd5, 8'd3, 1'b1}) $display("FAIL mid_pre got=%0d/%0d/%b exp=5/3/1", count0, count1, next_lane);
        else n_pass++;
        n_check++;
        if ({out0_valid, out1_valid} !== 2'b11) $display("FAIL mid_full got=%b exp=11", {out0_valid, out1_valid});
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        clear_model();
        n_check++;
        if ({out0_valid, out1_valid, next_lane, in_ready} !== 4'b0001) $display("FAIL mid_rst_flags got=%b exp=0001", {out0_valid, out1_valid, next_lane, in_ready});
        else n_pass++;
        n_check++;
        if ({out0_data, out1_data, count0, count1} !== 32'h0) $display("FAIL mid_rst_regs got=%h exp=0", {out0_data, out1_data, count0, count1});
        else n_pass++;
        rst_n = 1'b1;
        cyc();
        cyc();
        n_check++;
        if ({count0, count1} !== 16'h0000) $display("FAIL mid_no_delivery got=%0d/%0d exp=0/0", count0, count1);
        else n_pass++;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(8'h99, 1'b1);
        in_valid = 1'b0;
        n_check++;
        if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'h99, 1'b0}) $display("FAIL mid_first_word got=%b/%h/%b exp=1/99/0", out0_valid, out0_data, out1_valid);
        else n_pass++;
        cyc();
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_check = 0;
        n_pass  = 0;
        test_reset();
        test_steer();
        test_backpressure();
        test_independent();
        test_alternate();
        test_wrap();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
